// File: rtl/two_power_arbiter.sv
// two_power_arbiter: round-robin arbiter that shares one 2^power mod modulus engine among N_REQ requesters,
// keeping exactly one engine job in flight and routing its result back to the owning requester.
module two_power_arbiter #(
  parameter int MOD_WIDTH = 256,
  parameter int INT_WIDTH = 32,
  parameter int N_REQ = 2,
  localparam int GW = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][INT_WIDTH-1:0]     req_power,
  input  logic [N_REQ-1:0][MOD_WIDTH-1:0]     req_modulus,
  output logic [N_REQ-1:0]                    rsp_valid,
  input  logic [N_REQ-1:0]                    rsp_ready,
  output logic [MOD_WIDTH-1:0]                rsp_result,
  output logic                                eng_i_valid,
  input  logic                                eng_i_ready,
  output logic [INT_WIDTH-1:0]                eng_power,
  output logic [MOD_WIDTH-1:0]                eng_modulus,
  input  logic                                eng_o_valid,
  output logic                                eng_o_ready,
  input  logic [MOD_WIDTH-1:0]                eng_result,
  output logic                                busy,
  output logic [GW-1:0]                       grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] last_grant, win;
  logic found;
  logic [INT_WIDTH-1:0] power_q;
  logic [MOD_WIDTH-1:0] modulus_q, result_q;
  // search downward so the requester nearest after last_grant is the final (winning) assignment
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req_valid[(int'(last_grant) + i) % N_REQ]) begin
        found = 1'b1;
        win = GW'((int'(last_grant) + i) % N_REQ);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = found ? ISSUE : IDLE;
      ISSUE:   state_nxt = eng_i_ready ? WAIT : ISSUE;
      WAIT:    state_nxt = eng_o_valid ? RESP : WAIT;
      RESP:    state_nxt = rsp_ready[grant_id] ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready   = (state == IDLE && found && rst_n) ? (N_REQ'(1) << win) : '0;
    rsp_valid   = (state == RESP) ? (N_REQ'(1) << grant_id) : '0;
    eng_i_valid = state == ISSUE;
    eng_o_ready = state == WAIT;
    busy        = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      power_q    <= '0;
      modulus_q  <= '0;
      result_q   <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_id  <= win;
        power_q   <= req_power[win];
        modulus_q <= req_modulus[win];
      end
      if (state == WAIT && eng_o_valid) result_q <= eng_result;
      if (state == RESP && rsp_ready[grant_id]) last_grant <= grant_id;
    end
  assign eng_power   = power_q;
  assign eng_modulus = modulus_q;
  assign rsp_result  = result_q;
endmodule

// File: tb/tb_two_power_arbiter.sv
// tb_two_power_arbiter: directed bench with a behavioural 2^p mod m engine and hand-computed expected results.
module tb_two_power_arbiter;
  localparam int MW = 256;
  localparam int IW = 32;
  localparam int N  = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] rsp_ready = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [N-1:0][IW-1:0] req_power = '0;
  logic [N-1:0][MW-1:0] req_modulus = '0;
  logic [MW-1:0] rsp_result, eng_modulus, eng_result;
  logic [IW-1:0] eng_power;
  logic eng_i_valid, eng_i_ready, eng_o_valid, eng_o_ready, busy;
  logic [0:0] grant_id;
  int checks = 0;
  int errors = 0;
  logic eng_block = 1'b0;
  int eng_lat = 0;
  logic e_busy;
  int e_cnt;
  logic [MW-1:0] e_res;

  always #5 clk = ~clk;

  two_power_arbiter #(.MOD_WIDTH(MW), .INT_WIDTH(IW), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_power(req_power), .req_modulus(req_modulus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready), .eng_power(eng_power), .eng_modulus(eng_modulus),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_result(eng_result),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [MW-1:0] pow2mod(input logic [IW-1:0] p, input logic [MW-1:0] m);
    logic [2*MW-1:0] r, mm;
    mm = {{MW{1'b0}}, m};
    r = 1;
    r = r % mm;
    for (int i = IW - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (p[i]) r = (r << 1) % mm;
    end
    return r[MW-1:0];
  endfunction

  assign eng_i_ready = !eng_block && !e_busy;
  assign eng_o_valid = e_busy && e_cnt == 0;
  assign eng_result  = e_res;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_busy <= 1'b0;
      e_cnt <= 0;
      e_res <= '0;
    end else if (eng_i_valid && eng_i_ready) begin
      e_busy <= 1'b1;
      e_cnt <= eng_lat;
      e_res <= pow2mod(eng_power, eng_modulus);
    end else if (eng_o_valid && eng_o_ready) e_busy <= 1'b0;
    else if (e_busy && e_cnt > 0) e_cnt <= e_cnt - 1;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic [N-1:0] ev, input string tag);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, req_ready, ev);
  endtask

  task automatic wait_rsp(input logic [N-1:0] ev, input logic [MW-1:0] er, input int hold, input string tag);
    int n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, ev);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_grant"}, grant_id, ev[1]);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~ev;
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, ev);
      check({tag, "_hold_result"}, rsp_result, er);
      check({tag, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = '0;
    tick();
    rsp_ready = ev;
    tick();
    rsp_ready = '0;
  endtask

  task automatic do_job(input int r, input logic [IW-1:0] p, input logic [MW-1:0] m, input logic [MW-1:0] e, input string tag);
    tick();
    req_valid[r] = 1'b1;
    req_power[r] = p;
    req_modulus[r] = m;
    wait_ready(N'(1) << r, {tag, "_accept"});
    tick();
    req_valid[r] = 1'b0;
    wait_rsp(N'(1) << r, e, 0, tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_eng_i_valid"}, eng_i_valid, 0);
    check({tag, "_eng_o_ready"}, eng_o_ready, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_eng_power"}, eng_power, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
  endtask

  initial begin
    int n;
    // contention jobs: 2^5 mod 7 = 4, 2^10 mod 1000 = 24
    req_power[0] = 5;
    req_modulus[0] = 7;
    req_power[1] = 10;
    req_modulus[1] = 1000;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready((k % 2 == 0) ? 2'b01 : 2'b10, "rr_grant");
      tick();
      wait_rsp((k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 4 : 24, 0, "rr");
    end
    req_valid = '0;
    // single job: 2^4 mod 13 = 3
    do_job(0, 4, 13, 3, "single");
    // operand isolation: 2^6 mod 10 = 4 despite later operand changes
    tick();
    req_valid[0] = 1'b1;
    req_power[0] = 6;
    req_modulus[0] = 10;
    wait_ready(2'b01, "iso_accept");
    tick();
    req_valid[0] = 1'b0;
    req_power[0] = 2;
    req_modulus[0] = 3;
    @(negedge clk);
    check("iso_eng_power", eng_power, 6);
    check("iso_eng_modulus", eng_modulus, 10);
    wait_rsp(2'b01, 4, 0, "iso");
    // back-pressure: engine stalls 5 cycles, response held 10 cycles; 2^8 mod 255 = 1
    eng_block = 1'b1;
    tick();
    req_valid[0] = 1'b1;
    req_power[0] = 8;
    req_modulus[0] = 255;
    wait_ready(2'b01, "bp_accept");
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    req_power[1] = 3;
    req_modulus[1] = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_eng_i_valid", eng_i_valid, 1);
      check("bp_eng_power", eng_power, 8);
      check("bp_eng_modulus", eng_modulus, 255);
      check("bp_req_ready", req_ready, 0);
    end
    tick();
    eng_block = 1'b0;
    wait_rsp(2'b01, 1, 10, "bp");
    wait_ready(2'b10, "bp_next_accept");
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(2'b10, 3, 0, "bp_next");
    // late request during WAIT: 2^7 mod 100 = 28, then 2^0 mod 11 = 1
    eng_lat = 5;
    tick();
    req_valid[0] = 1'b1;
    req_power[0] = 7;
    req_modulus[0] = 100;
    wait_ready(2'b01, "late_accept");
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!eng_o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("late_in_wait", eng_o_ready, 1);
    req_valid[1] = 1'b1;
    req_power[1] = 0;
    req_modulus[1] = 11;
    #1;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      check("late_hold_ready", req_ready, 0);
      @(negedge clk);
      n++;
    end
    wait_rsp(2'b01, 28, 0, "late_first");
    wait_ready(2'b10, "late_accept2");
    tick();
    req_valid[1] = 1'b0;
    eng_lat = 0;
    wait_rsp(2'b10, 1, 0, "late_second");
    // reset mid-WAIT: requester 1 job discarded, requester 0 wins next (2^3 mod 5 = 3)
    do_job(0, 3, 5, 3, "pre_rst");
    eng_lat = 30;
    tick();
    req_valid[1] = 1'b1;
    req_power[1] = 5;
    req_modulus[1] = 7;
    wait_ready(2'b10, "rst_accept");
    tick();
    req_valid[1] = 1'b0;
    n = 0;
    while (!eng_o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_in_wait", busy, 1);
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_power[0] = 3;
    req_modulus[0] = 5;
    eng_lat = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle_outputs("midrst");
    end
    tick();
    rst_n = 1'b1;
    wait_ready(2'b01, "post_rst_grant");
    tick();
    req_valid = '0;
    wait_rsp(2'b01, 3, 0, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
